ring_step_arbiter: RTL
======================

RING_STEP_ARBITER -- requirements
Module: ring_step_arbiter

Interface
REQ-001 SHALL have these ports, clock and reset first:
  clk       in   1  clock, all state on rising edge
  rst_n     in   1  reset, asynchronous, active-low
  req       in   2  per-requester job request, level, held until gnt
  dir0      in   1  requester 0 direction: 0 = up (+1 mod 4), 1 = down (-1 mod 4)
  dir1      in   1  requester 1 direction, same encoding
  cnt0      in   4  requester 0 step count, 0..15
  cnt1      in   4  requester 1 step count, 0..15
  gnt       out  2  one-hot, 1 cycle: job accepted this cycle
  done      out  2  one-hot, 1 cycle: granted job complete
  busy      out  1  high whenever not IDLE
  pos       out  2  current ring position 0..3
  y         out  1  high iff pos == 3
  hit_cnt   out  4  entries into pos 3 during last/current job, saturating
REQ-002 SHALL have no parameters; widths are fixed as above.

Function
REQ-003 Ring SHALL step only when enabled: up 0->1->2->3->0, down 0->3->2->1->0; hold otherwise.
REQ-004 Controller FSM SHALL have states IDLE, RUN, DONE.
REQ-005 IDLE: if any req bit set, SHALL grant exactly one requester; gnt is combinational from req and the round-robin pointer in that cycle.
REQ-006 Arbitration SHALL be round-robin: when both request, grant the one not granted last; after reset requester 0 wins the first tie.
REQ-007 On grant SHALL latch owner, dir and cnt of the winner, clear hit_cnt, go to RUN if cnt != 0, else DONE.
REQ-008 RUN: each cycle SHALL step ring once in latched dir and decrement remaining count; after the Nth step go to DONE.
REQ-009 Latency: gnt in cycle t; pos changes at edges ending cycles t+1..t+N; done[owner] high in cycle t+N+1; next gnt no earlier than t+N+2.
REQ-010 cnt = 0 SHALL give done in cycle t+1 with no ring step and hit_cnt = 0.
REQ-011 DONE: SHALL pulse done[owner] for one cycle, record owner as last-granted, return to IDLE.
REQ-012 hit_cnt SHALL increment on each step landing on pos 3, saturate at 15, hold its value after done until the next grant; starting at pos 3 does not count.
REQ-013 req, dir, cnt SHALL be ignored outside IDLE; req dropped before gnt has no effect.
REQ-014 pos persists across jobs; it is never reset by a grant.
REQ-015 gnt and done SHALL never be asserted together.

Reset
REQ-016 rst_n low SHALL asynchronously force: FSM IDLE, pos 0, y 0, gnt 0, done 0, busy 0, hit_cnt 0, remaining count 0, round-robin pointer to favour requester 0.
REQ-017 Reset mid-RUN SHALL abort the job with no done pulse; operation resumes from IDLE on the first edge after release.

Structure
REQ-018 A shared package SHALL hold the FSM state enum (IDLE/RUN/DONE), ring position constants P0..P3, DIR_UP = 0, DIR_DOWN = 1.
REQ-019 The ring SHALL be a sub-module ring_mod4_step (clk, rst_n, en, dir -> pos, y), instantiated once.
REQ-020 The arbiter/controller SHALL be in the top module; the ring pos is the only shared resource.

Verification
REQ-021 Reset, req0=1 dir0=0 cnt0=5 -> gnt=01 cycle t; pos 1,2,3,0,1; done=01 at t+6; hit_cnt=1.
REQ-022 pos=1, req1=1 dir1=1 cnt1=3 -> pos 0,3,2; done=10; hit_cnt=1; y high exactly one cycle.
REQ-023 req=11 held continuously, cnt0=cnt1=1 -> grants alternate 01,10,01,10; each gnt 3 cycles apart.
REQ-024 req0=1 cnt0=0 -> gnt=01 then done=01 next cycle; pos unchanged; hit_cnt=0.
REQ-025 req0=1 dir0=0 cnt0=15 from pos 0 -> hit_cnt=4; then rst_n pulse low at 3rd RUN cycle -> pos=0, busy=0, no done.
REQ-026 Change dir0/cnt0 during RUN -> job proceeds with latched values, completion timing unchanged.

Source files
------------

// File: rtl/ring_step_arbiter_pkg.sv
// Shared definitions for the ring step arbiter: controller states,
// ring position constants and direction encoding.
package ring_step_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Position reached by one step from p in direction d.
    function automatic logic [1:0] ring_step(input logic [1:0] p, input logic d);
        return (d == DIR_DOWN) ? (p - 2'd1) : (p + 2'd1);
    endfunction

endpackage

// File: rtl/ring_mod4_step.sv
// Four-position ring counter: steps one place up or down when enabled,
// holds otherwise. y flags position 3.
module ring_mod4_step
    import ring_step_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       dir,
    output logic [1:0] pos,
    output logic       y
);

    logic [1:0] r_pos;

    // Ring position register, stepping only when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos <= P0;
        end else if (en) begin
            r_pos <= ring_step(r_pos, dir);
        end
    end

    assign pos = r_pos;
    assign y   = (r_pos == P3);

endmodule

// File: rtl/ring_step_arbiter.sv
// Two-requester round-robin arbiter that owns a shared mod-4 ring.
// A granted job steps the ring cnt times in the requested direction,
// counts landings on position 3, then pulses done for its owner.
module ring_step_arbiter
    import ring_step_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       dir0,
    input  logic       dir1,
    input  logic [3:0] cnt0,
    input  logic [3:0] cnt1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       busy,
    output logic [1:0] pos,
    output logic       y,
    output logic [3:0] hit_cnt
);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_owner;
    logic       r_dir;
    logic       r_last_gnt;
    logic [3:0] r_remaining;
    logic [3:0] r_hit_cnt;

    logic       w_grant;
    logic       w_win;
    logic       w_win_dir;
    logic [3:0] w_win_cnt;
    logic       w_ring_en;
    logic [1:0] w_gnt;
    logic [1:0] w_done;
    logic [1:0] w_land;

    // Winner selection: a lone requester wins, a tie goes to whoever
    // was not granted last (r_last_gnt resets to 1 so requester 0 wins first).
    assign w_win     = (req == 2'b11) ? ~r_last_gnt : req[1];
    assign w_win_dir = w_win ? dir1 : dir0;
    assign w_win_cnt = w_win ? cnt1 : cnt0;

    // Next-state and output decode for the IDLE/RUN/DONE controller.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_gnt        = 2'b00;
        w_done       = 2'b00;
        w_ring_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    w_grant      = 1'b1;
                    w_gnt        = w_win ? 2'b10 : 2'b01;
                    w_state_next = (w_win_cnt != 4'd0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                w_ring_en = 1'b1;
                if (r_remaining == 4'd1) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done       = r_owner ? 2'b10 : 2'b01;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Job context: latch winner on grant, count down steps while running,
    // remember the owner as last-granted when the job completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= 1'b0;
            r_dir       <= DIR_UP;
            r_remaining <= 4'd0;
            r_last_gnt  <= 1'b1;
        end else begin
            if (w_grant) begin
                r_owner     <= w_win;
                r_dir       <= w_win_dir;
                r_remaining <= w_win_cnt;
            end else if (w_ring_en) begin
                r_remaining <= r_remaining - 4'd1;
            end
            if (r_state == ST_DONE) begin
                r_last_gnt <= r_owner;
            end
        end
    end

    // Position the ring lands on after this cycle's step.
    assign w_land = ring_step(pos, r_dir);

    // Saturating count of steps landing on position 3; cleared on grant,
    // held after completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt <= 4'd0;
        end else if (w_grant) begin
            r_hit_cnt <= 4'd0;
        end else if (w_ring_en && (w_land == P3) && (r_hit_cnt != 4'd15)) begin
            r_hit_cnt <= r_hit_cnt + 4'd1;
        end
    end

    ring_mod4_step u_ring (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_ring_en),
        .dir   (r_dir),
        .pos   (pos),
        .y     (y)
    );

    // gnt is combinational from req, so it is masked while reset is held.
    assign gnt     = w_gnt & {2{rst_n}};
    assign done    = w_done;
    assign busy    = (r_state != ST_IDLE);
    assign hit_cnt = r_hit_cnt;

endmodule
